// File: rtl/lis_bus_arbiter.sv
// rtl/lis_bus_arbiter.sv - cpu/DMA arbiter for the single byte-wide memory port; LIS_ARB_STATS_EN adds stall/burst counters
module lis_bus_arbiter #(
    parameter int MAX_BURST = 16,
    parameter int CPU_SLICE = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] cpu_address,
    input  logic [7:0]  cpu_out,
    input  logic        cpu_we,
    output logic        cpu_ce,
    output logic [7:0]  cpu_in,
    input  logic        dma_req,
    input  logic [31:0] dma_address,
    input  logic [7:0]  dma_out,
    input  logic        dma_we,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [7:0]  dma_in,
    output logic [31:0] mem_address,
    output logic [7:0]  mem_out,
    output logic        mem_we,
    input  logic [7:0]  mem_in
`ifdef LIS_ARB_STATS_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [15:0] burst_total
`endif
);

    typedef enum logic [1:0] {
        S_CPU  = 2'd0,
        S_HAND = 2'd1,
        S_DMA  = 2'd2,
        S_RET  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] burst_cnt;
    logic [7:0] slice_cnt;
    logic       burst_last;

    assign burst_last = (burst_cnt == 8'(MAX_BURST - 1));

    always_comb begin
        state_next = state;
        case (state)
            S_CPU:  if (dma_req && slice_cnt == 8'd0) state_next = S_HAND;
            S_HAND: state_next = S_DMA;
            S_DMA:  if (!dma_req || burst_last) state_next = S_RET;
            S_RET:  state_next = S_CPU;
            default: state_next = S_CPU;
        endcase
    end

    // cpu_ce is the registered image of "next state is S_CPU"
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= S_CPU;
            cpu_ce     <= 1'b1;
            burst_cnt  <= 8'd0;
            slice_cnt  <= 8'(CPU_SLICE);
            dma_rvalid <= 1'b0;
        end else begin
            state      <= state_next;
            cpu_ce     <= (state_next == S_CPU);
            dma_rvalid <= (state == S_DMA) && dma_req && !dma_we;
            case (state)
                S_CPU:  if (slice_cnt != 8'd0) slice_cnt <= slice_cnt - 8'd1;
                S_HAND: burst_cnt <= 8'd0;
                S_DMA:  burst_cnt <= burst_cnt + 8'd1;
                S_RET:  slice_cnt <= 8'(CPU_SLICE);
                default: ;
            endcase
        end
    end

    // A DMA cycle with dma_req low performs no access, so its write strobe is dropped too
    always_comb begin
        dma_gnt = (state == S_DMA);
        if (dma_gnt) begin
            mem_address = dma_address;
            mem_out     = dma_out;
            mem_we      = dma_we && dma_req;
        end else begin
            mem_address = cpu_address;
            mem_out     = cpu_out;
            mem_we      = cpu_we;
        end
    end

    assign cpu_in = mem_in;
    assign dma_in = mem_in;

`ifdef LIS_ARB_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_cnt   <= 32'd0;
            burst_total <= 16'd0;
        end else begin
            if (!cpu_ce) stall_cnt <= stall_cnt + 32'd1;
            if (state == S_HAND) burst_total <= burst_total + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lis_bus_arbiter.sv
// tb/tb_lis_bus_arbiter.sv - directed self-checking bench for lis_bus_arbiter
module tb_lis_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] cpu_address;
    logic [7:0]  cpu_out;
    logic        cpu_we;
    logic        cpu_ce;
    logic [7:0]  cpu_in;
    logic        dma_req;
    logic [31:0] dma_address;
    logic [7:0]  dma_out;
    logic        dma_we;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [7:0]  dma_in;
    logic [31:0] mem_address;
    logic [7:0]  mem_out;
    logic        mem_we;
    logic [7:0]  mem_in;
`ifdef LIS_ARB_STATS_EN
    logic [31:0] stall_cnt;
    logic [15:0] burst_total;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:1023];

    lis_bus_arbiter #(.MAX_BURST(16), .CPU_SLICE(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_address (cpu_address),
        .cpu_out     (cpu_out),
        .cpu_we      (cpu_we),
        .cpu_ce      (cpu_ce),
        .cpu_in      (cpu_in),
        .dma_req     (dma_req),
        .dma_address (dma_address),
        .dma_out     (dma_out),
        .dma_we      (dma_we),
        .dma_gnt     (dma_gnt),
        .dma_rvalid  (dma_rvalid),
        .dma_in      (dma_in),
        .mem_address (mem_address),
        .mem_out     (mem_out),
        .mem_we      (mem_we),
        .mem_in      (mem_in)
`ifdef LIS_ARB_STATS_EN
        ,
        .stall_cnt   (stall_cnt),
        .burst_total (burst_total)
`endif
    );

    always #5 clock = ~clock;

    // Memory with one cycle of read latency
    always @(posedge clock) begin
        if (mem_we) mem[mem_address[9:0]] <= mem_out;
        mem_in <= mem[mem_address[9:0]];
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) next_cycle();
    endtask

    logic g [0:39];
    logic c [0:39];
    logic r [0:39];
    logic [7:0] t3_exp [0:2];

    initial begin
        int first_gnt, gnt_run, ce_low, rv_cnt, gap, issued, recv, gcount, done, first_after;
        for (int k = 0; k < 1024; k++) mem[k] = 8'h00;
        mem[10'h100] = 8'hA1;
        mem[10'h101] = 8'hA2;
        mem[10'h102] = 8'hA3;
        t3_exp[0] = 8'hA1;
        t3_exp[1] = 8'hA2;
        t3_exp[2] = 8'hA3;

        reset_n = 1'b0;
        cpu_address = 32'h0; cpu_out = 8'h0; cpu_we = 1'b0;
        dma_req = 1'b0; dma_address = 32'h0; dma_out = 8'h0; dma_we = 1'b0;
        idle(3);
        @(negedge clock);
        check("rst_cpu_ce", 32'(cpu_ce), 32'd1);
        check("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        next_cycle();
        reset_n = 1'b1;

        // Test 1: cpu alone, addresses pass straight through
        for (int i = 0; i < 16; i++) begin
            cpu_address = 32'h10 + 32'(i);
            @(negedge clock);
            check("t1_cpu_ce", 32'(cpu_ce), 32'd1);
            check("t1_mem_addr", mem_address, 32'h10 + 32'(i));
            next_cycle();
        end

        // Test 2: held request, full bursts
        dma_req = 1'b1; dma_we = 1'b0; dma_address = 32'h100;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            g[i] = dma_gnt; c[i] = cpu_ce; r[i] = dma_rvalid;
            if (i == 2) check("t2_dma_mux", mem_address, 32'h100);
            next_cycle();
        end
        first_gnt = 99;
        for (int i = 39; i >= 0; i--) if (g[i] && (i == 0 || !g[i-1]) && i < 20) first_gnt = i;
        gnt_run = 0; ce_low = 0; rv_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (g[i]) gnt_run++;
            if (!c[i]) ce_low++;
            if (r[i]) rv_cnt++;
        end
        gap = 0;
        for (int i = 19; i < 40 && c[i]; i++) gap++;
        check("t2_first_gnt", 32'(first_gnt), 32'd2);
        check("t2_gnt_cycles", 32'(gnt_run), 32'd16);
        check("t2_ce_low", 32'(ce_low), 32'd18);
        check("t2_rvalid_cnt", 32'(rv_cnt), 32'd16);
        check("t2_rvalid_in_ret", {30'd0, r[18], g[18]}, 32'd2);
        check("t2_slice_gap", 32'(gap), 32'd5);
        check("t2_regrant", 32'(c[24]), 32'd0);
        dma_req = 1'b0;
        idle(30);

        // Test 3: DMA reads three bytes
        dma_req = 1'b1; dma_we = 1'b0; dma_address = 32'h100;
        issued = 0; recv = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clock);
            if (dma_rvalid) begin
                if (recv < 3) check("t3_rdata", 32'(dma_in), 32'(t3_exp[recv]));
                recv++;
            end
            if (dma_gnt && dma_req) issued++;
            next_cycle();
            if (issued >= 3) dma_req = 1'b0;
            else dma_address = 32'h100 + 32'(issued);
        end
        check("t3_rvalid_cnt", 32'(recv), 32'd3);
        idle(8);

        // Test 4: cpu write registered as the request rises lands in S_HAND
        dma_req = 1'b1; dma_we = 1'b1; dma_address = 32'h300; dma_out = 8'hC0;
        issued = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clock);
            if (cyc == 1) begin
                check("t4_hand_we", 32'(mem_we), 32'd1);
                check("t4_hand_addr", mem_address, 32'h200);
            end
            if (dma_gnt && dma_req) issued++;
            next_cycle();
            if (cyc == 0) begin
                cpu_we = 1'b1; cpu_address = 32'h200; cpu_out = 8'h5A;
            end else if (cpu_ce) begin
                cpu_we = 1'b0;
            end
            if (issued >= 4) begin
                dma_req = 1'b0; dma_we = 1'b0;
            end else begin
                dma_address = 32'h300 + 32'(issued);
                dma_out = 8'hC0 + 8'(issued);
            end
        end
        check("t4_cpu_write", 32'(mem[10'h200]), 32'h5A);
        for (int i = 0; i < 4; i++) check("t4_dma_write", 32'(mem[10'h300 + 10'(i)]), 32'hC0 + 32'(i));
        check("t4_issued", 32'(issued), 32'd4);
        idle(8);

        // Test 5: reset in the burst cycle with burst_cnt=5
        dma_req = 1'b1; dma_we = 1'b0; dma_address = 32'h100;
        gcount = 0; done = 0;
        for (int cyc = 0; cyc < 40 && done == 0; cyc++) begin
            @(negedge clock);
            if (dma_gnt) gcount++;
            next_cycle();
            if (gcount == 5) begin
                reset_n = 1'b0;
                done = 1;
            end
        end
        check("t5_reached", 32'(done), 32'd1);
        next_cycle();
        reset_n = 1'b1;
        @(negedge clock);
        check("t5_cpu_ce", 32'(cpu_ce), 32'd1);
        check("t5_dma_gnt", 32'(dma_gnt), 32'd0);
        check("t5_dma_rvalid", 32'(dma_rvalid), 32'd0);
        first_after = 99;
        for (int k = 1; k < 20 && first_after == 99; k++) begin
            next_cycle();
            @(negedge clock);
            if (dma_gnt) first_after = k;
        end
        check("t5_first_gnt_after_rst", 32'(first_after), 32'd6);
        next_cycle();
        dma_req = 1'b0;
        idle(30);

`ifdef LIS_ARB_STATS_EN
        // Test 6: two full bursts from reset
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        @(negedge clock);
        check("t6_stall_rst", stall_cnt, 32'd0);
        check("t6_bursts_rst", 32'(burst_total), 32'd0);
        next_cycle();
        dma_req = 1'b1;
        gcount = 0;
        begin
            logic prev_ce;
            prev_ce = 1'b1;
            for (int cyc = 0; cyc < 100 && gcount < 2; cyc++) begin
                @(negedge clock);
                if (cpu_ce && !prev_ce) gcount++;
                prev_ce = cpu_ce;
                if (gcount < 2) next_cycle();
            end
        end
        check("t6_rises", 32'(gcount), 32'd2);
        check("t6_stall_cnt", stall_cnt, 32'd36);
        check("t6_burst_total", 32'(burst_total), 32'd2);
        next_cycle();
        dma_req = 1'b0;
        idle(4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
